// File: rtl/msb_word_serializer_if.sv
// Parallel-in / serial-out handshake bundle for msb_word_serializer.
// slave  : the serializer side (accepts words, drives the serial stream)
// master : the word source / serial consumer side
interface msb_word_serializer_if #(
   parameter int WIDTH = 8
) ();
   logic [WIDTH-1:0] din;
   logic             din_valid;
   logic             din_ready;
   logic             sout;
   logic             sout_valid;
   logic             sof;
   logic             eof;
   logic             busy;

   modport slave (
      input  din,
      input  din_valid,
      output din_ready,
      output sout,
      output sout_valid,
      output sof,
      output eof,
      output busy
   );

   modport master (
      output din,
      output din_valid,
      input  din_ready,
      input  sout,
      input  sout_valid,
      input  sof,
      input  eof,
      input  busy
   );
endinterface

// File: rtl/msb_word_serializer.sv
// msb_word_serializer: takes parallel words over valid/ready and shifts them
// out MSB-first with sof/eof strobes, feeding the serial divisible-by-5 detector.
// Optional build macro REF_MOD5_EN adds an in-line mod-5 golden residue
// (ref_rem / ref_valid) computed from the emitted bit stream.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for a word, din_ready=1
// S_SHIFT | emitting bit r_bit_cnt of the frame (MSB first)
// S_GAP   | forced idle bubble between frames, r_gap_cnt counts down
module msb_word_serializer #(
   parameter int WIDTH = 8,
   parameter int GAP   = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   msb_word_serializer_if.slave      bus
`ifdef REF_MOD5_EN
   ,
   output logic [2:0]                ref_rem,
   output logic                      ref_valid
`endif
);

   localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);
   localparam logic [3:0]     GAP_LOAD = 4'((GAP > 0) ? GAP - 1 : 0);
   localparam bit             GAP_NONE = (GAP == 0);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   state_t           r_state,   w_state_nxt;
   logic [WIDTH-1:0] r_shreg,   w_shreg_nxt;
   logic [CW-1:0]    r_bit_cnt, w_bit_cnt_nxt;
   logic [3:0]       r_gap_cnt, w_gap_cnt_nxt;

   logic w_last;
   logic w_ready;
   logic w_xfer;

   // Ready is decoded from registered state only, never from din_valid.
   assign w_last  = (r_state == S_SHIFT) && (r_bit_cnt == LAST_BIT);
   assign w_ready = (r_state == S_IDLE) || (w_last && GAP_NONE);
   assign w_xfer  = bus.din_valid && w_ready;

   // State register: FSM state, shift register and both counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_shreg   <= '0;
         r_bit_cnt <= '0;
         r_gap_cnt <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_shreg   <= w_shreg_nxt;
         r_bit_cnt <= w_bit_cnt_nxt;
         r_gap_cnt <= w_gap_cnt_nxt;
      end
   end

   // Next-state logic: load on transfer, shift per bit, count down the gap.
   always_comb begin
      w_state_nxt   = r_state;
      w_shreg_nxt   = r_shreg;
      w_bit_cnt_nxt = r_bit_cnt;
      w_gap_cnt_nxt = r_gap_cnt;
      case (r_state)
         S_IDLE: begin
            if (w_xfer) begin
               w_state_nxt   = S_SHIFT;
               w_shreg_nxt   = bus.din;
               w_bit_cnt_nxt = '0;
            end
         end
         S_SHIFT: begin
            if (w_last) begin
               if (!GAP_NONE) begin
                  w_state_nxt   = S_GAP;
                  w_gap_cnt_nxt = GAP_LOAD;
               end else if (w_xfer) begin
                  // back-to-back: next cycle is the new frame's sof
                  w_shreg_nxt   = bus.din;
                  w_bit_cnt_nxt = '0;
               end else begin
                  w_state_nxt   = S_IDLE;
               end
            end else begin
               w_shreg_nxt   = {r_shreg[WIDTH-2:0], 1'b0};
               w_bit_cnt_nxt = r_bit_cnt + 1'b1;
            end
         end
         S_GAP: begin
            if (r_gap_cnt == 4'd0) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_gap_cnt_nxt = r_gap_cnt - 4'd1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Output decode: all outputs are functions of registered state only.
   always_comb begin
      bus.din_ready  = w_ready;
      bus.sout_valid = (r_state == S_SHIFT);
      bus.sout       = (r_state == S_SHIFT) && r_shreg[WIDTH-1];
      bus.sof        = (r_state == S_SHIFT) && (r_bit_cnt == '0);
      bus.eof        = w_last;
      bus.busy       = (r_state == S_SHIFT) || (r_state == S_GAP);
   end

`ifdef REF_MOD5_EN
   logic [2:0] r_res;
   logic [2:0] r_ref_rem;
   logic       r_ref_valid;
   logic [2:0] w_res_prev;
   logic [3:0] w_res_sum;
   logic [2:0] w_res_new;

   // Residue step r = (2*r_prev + bit) mod 5; r_prev is forced to 0 on sof.
   always_comb begin
      w_res_prev = (r_bit_cnt == '0) ? 3'd0 : r_res;
      w_res_sum  = {w_res_prev, bus.sout};
      w_res_new  = (w_res_sum >= 4'd5) ? 3'(w_res_sum - 4'd5) : 3'(w_res_sum);
   end

   // Residue accumulate per SHIFT cycle; publish the final value after eof.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_res       <= 3'd0;
         r_ref_rem   <= 3'd0;
         r_ref_valid <= 1'b0;
      end else begin
         r_ref_valid <= w_last;
         if (r_state == S_SHIFT) begin
            r_res <= w_res_new;
         end
         if (w_last) begin
            r_ref_rem <= w_res_new;
         end
      end
   end

   assign ref_rem   = r_ref_rem;
   assign ref_valid = r_ref_valid;
`endif

endmodule
